// File: rtl/cpu_instruction_cache_if.sv
// Fetch-side and fill-side signals of the instruction cache.
// The cache is the slave; the CPU pipeline plus memory arbiter act as master.
interface cpu_instruction_cache_if #(
  parameter int ADDRESS_BITS = 15,
  parameter int BITS         = 16
);
  logic [ADDRESS_BITS-1:0]    cache_request_address;
  logic [ADDRESS_BITS+BITS:0] cache_line;
  logic                       cache_miss;
  logic                       cache_flush;
  logic                       mem_request;
  logic [ADDRESS_BITS-1:0]    mem_address;
  logic [BITS-1:0]            mem_data;
  logic                       mem_success;

  modport slave (
    input  cache_request_address, cache_flush, mem_data, mem_success,
    output cache_line, cache_miss, mem_request, mem_address
  );

  modport master (
    output cache_request_address, cache_flush, mem_data, mem_success,
    input  cache_line, cache_miss, mem_request, mem_address
  );
endinterface

// File: rtl/cpu_instruction_cache.sv
// Direct-mapped instruction cache, one instruction per line, synchronous-read arrays.
// Misses are filled from instruction memory through a request/success handshake.
module cpu_instruction_cache #(
  parameter int ADDRESS_BITS = 15,
  parameter int INDEX_BITS   = 8,
  parameter int BITS         = 16
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  cpu_instruction_cache_if.slave bus
);
  localparam int TAG_BITS = ADDRESS_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} state_t;

  logic [BITS-1:0]     data_mem  [LINES];
  logic [TAG_BITS-1:0] tag_mem   [LINES];
  logic                valid_mem [LINES];

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   flush_cnt_q, flush_cnt_d;
  logic                    flush_pending_q, flush_pending_d;
  logic                    write_last_q, write_last_d;
  logic [ADDRESS_BITS-1:0] addr_r_q, addr_r_d;
  logic                    mem_request_q, mem_request_d;
  logic [ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
  logic [BITS-1:0]         fill_data_q, fill_data_d;
  logic [BITS-1:0]         rd_data_q, rd_data_d;
  logic [TAG_BITS-1:0]     rd_tag_q, rd_tag_d;
  logic                    rd_valid_q, rd_valid_d;

  logic [INDEX_BITS-1:0]   req_idx;
  logic [INDEX_BITS-1:0]   addr_r_idx;
  logic [TAG_BITS-1:0]     addr_r_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]     fill_tag;
  logic                    lookup_miss;
  logic                    arr_we;
  logic                    vld_we;
  logic [INDEX_BITS-1:0]   vld_idx;
  logic                    vld_wdata;

  assign req_idx     = bus.cache_request_address[INDEX_BITS-1:0];
  assign addr_r_idx  = addr_r_q[INDEX_BITS-1:0];
  assign addr_r_tag  = addr_r_q[ADDRESS_BITS-1:INDEX_BITS];
  assign fill_idx    = mem_address_q[INDEX_BITS-1:0];
  assign fill_tag    = mem_address_q[ADDRESS_BITS-1:INDEX_BITS];
  assign lookup_miss = ~rd_valid_q | (rd_tag_q != addr_r_tag);

  // The cycle after any array write the read registers still hold pre-write contents.
  assign bus.cache_miss  = lookup_miss | (state_q != IDLE) | write_last_q;
  assign bus.cache_line  = {rd_tag_q, addr_r_idx, rd_valid_q, rd_data_q};
  assign bus.mem_request = mem_request_q;
  assign bus.mem_address = mem_address_q;

  assign arr_we    = (state_q == WRITE);
  assign vld_we    = (state_q == WRITE) | (state_q == FLUSH);
  assign vld_idx   = (state_q == WRITE) ? fill_idx : flush_cnt_q;
  assign vld_wdata = (state_q == WRITE);

  always_comb begin
    rd_data_d  = data_mem[req_idx];
    rd_tag_d   = tag_mem[req_idx];
    rd_valid_d = valid_mem[req_idx];
  end

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    flush_pending_d = flush_pending_q;
    write_last_d    = 1'b0;
    addr_r_d        = bus.cache_request_address;
    mem_request_d   = mem_request_q;
    mem_address_d   = mem_address_q;
    fill_data_d     = fill_data_q;
    unique case (state_q)
      IDLE: begin
        if (flush_pending_q || bus.cache_flush) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end else if (lookup_miss && !write_last_q) begin
          state_d       = FILL;
          mem_request_d = 1'b1;
          mem_address_d = addr_r_q;
        end
      end
      FILL: begin
        if (bus.cache_flush) flush_pending_d = 1'b1;
        if (bus.mem_success) begin
          fill_data_d   = bus.mem_data;
          mem_request_d = 1'b0;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        if (bus.cache_flush) flush_pending_d = 1'b1;
        state_d      = IDLE;
        write_last_d = 1'b1;
      end
      FLUSH: begin
        if (bus.cache_flush) begin
          flush_pending_d = 1'b1;
          flush_cnt_d     = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + INDEX_BITS'(1);
          if (flush_cnt_q == '1) begin
            flush_pending_d = 1'b0;
            write_last_d    = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // Storage arrays carry no reset; valid bits are cleared by the flush walk.
  always_ff @(posedge CLK) begin
    if (arr_we) begin
      data_mem[fill_idx] <= fill_data_q;
      tag_mem[fill_idx]  <= fill_tag;
    end
    if (vld_we) valid_mem[vld_idx] <= vld_wdata;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q         <= FLUSH;
      flush_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
      write_last_q    <= 1'b0;
      addr_r_q        <= '0;
      mem_request_q   <= 1'b0;
      mem_address_q   <= '0;
      fill_data_q     <= '0;
      rd_data_q       <= '0;
      rd_tag_q        <= '0;
      rd_valid_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      flush_pending_q <= flush_pending_d;
      write_last_q    <= write_last_d;
      addr_r_q        <= addr_r_d;
      mem_request_q   <= mem_request_d;
      mem_address_q   <= mem_address_d;
      fill_data_q     <= fill_data_d;
      rd_data_q       <= rd_data_d;
      rd_tag_q        <= rd_tag_d;
      rd_valid_q      <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_cpu_instruction_cache.sv
// Scoreboard bench for cpu_instruction_cache: stimulus queues expected hit lines and
// fill addresses; a hit monitor and a memory responder pop and compare them.
module tb_cpu_instruction_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_instruction_cache_if #(.ADDRESS_BITS(15), .BITS(16)) bus ();

  cpu_instruction_cache #(.ADDRESS_BITS(15), .INDEX_BITS(8), .BITS(16)) dut (
    .CLK  (clk),
    .RSTb (rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int fills_done = 0;
  int fill_delay = 2;
  logic [14:0] fill_q [$];
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    case (a)
      15'h0010: mem_word = 16'h1234;
      15'h0110: mem_word = 16'hBEEF;
      15'h0011: mem_word = 16'h1111;
      15'h0012: mem_word = 16'h2222;
      15'h0013: mem_word = 16'h3333;
      15'h0020: mem_word = 16'h2020;
      15'h0030: mem_word = 16'h3030;
      default:  mem_word = 16'hDEAD;
    endcase
  endfunction

  // Hit monitor
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && !bus.cache_miss && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("hit_line", bus.cache_line, mon_exp);
    end
  end

  // Memory responder
  logic [14:0] r_addr;
  logic        r_stable;
  initial begin
    bus.mem_success = 1'b0;
    bus.mem_data    = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_request) begin
        if (fill_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fill: mem_address 0x%04h, required no request", bus.mem_address);
          r_addr = bus.mem_address;
        end else begin
          r_addr = fill_q.pop_front();
          check("fill_addr", 32'(bus.mem_address), 32'(r_addr));
        end
        r_stable = 1'b1;
        repeat (fill_delay) begin
          @(negedge clk);
          if (!bus.mem_request || bus.mem_address !== r_addr) r_stable = 1'b0;
        end
        check("fill_addr_stable", 32'(r_stable), 32'd1);
        bus.mem_data    = mem_word(r_addr);
        bus.mem_success = 1'b1;
        @(negedge clk);
        bus.mem_success = 1'b0;
        bus.mem_data    = 16'h0000;
        check("mem_request_drop", 32'(bus.mem_request), 32'd0);
        fills_done++;
      end
    end
  end

  task automatic wait_hit(input logic [14:0] a, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (bus.cache_miss && cyc < max_cyc);
    if (bus.cache_miss) begin
      n_checks++;
      n_fail++;
      $display("FAIL hit_timeout: addr 0x%04h still missing after %0d cycles, required a hit", a, cyc);
    end
  endtask

  task automatic fetch(input logic [14:0] a, input logic [31:0] line, input bit exp_fill,
                       input int max_cyc, output int cyc);
    if (exp_fill) fill_q.push_back(a);
    exp_q.push_back(line);
    bus.cache_request_address = a;
    wait_hit(a, max_cyc, cyc);
  endtask

  task automatic wait_mem_request(input int max_cyc);
    int c;
    c = 0;
    while (!bus.mem_request && c < max_cyc) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("mem_request_seen", 32'(bus.mem_request), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [14:0] b2b_addr [4] = '{15'h0010, 15'h0011, 15'h0012, 15'h0013};
  logic [31:0] b2b_line [4] = '{32'h0021_1234, 32'h0023_1111, 32'h0025_2222, 32'h0027_3333};

  initial begin
    int c;
    int miss_bad;
    int req_bad;
    bus.cache_request_address = 15'h0010;
    bus.cache_flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cache_miss", 32'(bus.cache_miss), 32'd1);
    check("reset_mem_request", 32'(bus.mem_request), 32'd0);
    check("reset_cache_line", bus.cache_line, 32'h0000_0000);
    check("reset_mem_address", 32'(bus.mem_address), 32'd0);

    // Reset release: 256-cycle flush walk with no memory traffic
    rst_n = 1'b1;
    miss_bad = 0;
    req_bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!bus.cache_miss) miss_bad++;
      if (bus.mem_request) req_bad++;
    end
    check("flush_miss_cycles", 32'(miss_bad), 32'd0);
    check("flush_no_request", 32'(req_bad), 32'd0);

    // First fill
    fetch(15'h0010, 32'h0021_1234, 1'b1, 50, c);
    check("fills_after_first", 32'(fills_done), 32'd1);

    // Conflict on index 0x10
    fetch(15'h0110, 32'h0221_BEEF, 1'b1, 50, c);
    fetch(15'h0010, 32'h0021_1234, 1'b1, 50, c);
    check("fills_after_conflict", 32'(fills_done), 32'd3);

    // Preload and back-to-back hits
    fetch(15'h0011, 32'h0023_1111, 1'b1, 50, c);
    fetch(15'h0012, 32'h0025_2222, 1'b1, 50, c);
    fetch(15'h0013, 32'h0027_3333, 1'b1, 50, c);
    for (int i = 0; i < 4; i++) begin
      fetch(b2b_addr[i], b2b_line[i], 1'b0, 5, c);
      check("b2b_hit_cycles", 32'(c), 32'd1);
    end
    check("fills_after_b2b", 32'(fills_done), 32'd6);

    // Flush pulse while a fill is outstanding
    fill_delay = 5;
    fill_q.push_back(15'h0110);
    bus.cache_request_address = 15'h0110;
    wait_mem_request(20);
    fill_q.push_back(15'h0010);
    exp_q.push_back(32'h0021_1234);
    bus.cache_request_address = 15'h0010;
    bus.cache_flush = 1'b1;
    @(negedge clk);
    #1;
    bus.cache_flush = 1'b0;
    wait_hit(15'h0010, 400, c);
    check("flush_during_fill_wait_ge_261", 32'(c >= 261), 32'd1);
    fetch(15'h0011, 32'h0023_1111, 1'b1, 50, c);
    check("fills_after_flush", 32'(fills_done), 32'd9);

    // Request address moves during FILL
    fill_delay = 6;
    fill_q.push_back(15'h0020);
    bus.cache_request_address = 15'h0020;
    wait_mem_request(20);
    fill_q.push_back(15'h0030);
    exp_q.push_back(32'h0061_3030);
    bus.cache_request_address = 15'h0030;
    wait_hit(15'h0030, 60, c);
    fetch(15'h0020, 32'h0041_2020, 1'b0, 5, c);
    check("addr_change_hit_cycles", 32'(c), 32'd1);
    check("fills_after_addr_change", 32'(fills_done), 32'd11);

    repeat (2) @(negedge clk);
    check("hit_queue_empty", 32'(exp_q.size()), 32'd0);
    check("fill_queue_empty", 32'(fill_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
